// File: rtl/multiply_tokens_if.sv
// multiply_tokens_if -- token stream bundle for multiply_tokens.
//   a        : serial input token stream (1 = one token)
//   factor   : per-token multiplication factor, valid when a=1
//   b        : serial output stream
//   pending  : owed output '1's not yet emitted (PW bits)
//   busy     : pending != 0
//   overflow : sticky overflow flag
//   dropped  : dropped-token count, present only with MULTIPLY_TOKENS_DROP_CNT_EN
// Parameter PW must match the pending width derived inside multiply_tokens.
interface multiply_tokens_if #(
  parameter int unsigned PW = 10
);
  logic          a;
  logic [3:0]    factor;
  logic          b;
  logic [PW-1:0] pending;
  logic          busy;
  logic          overflow;
`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
  logic [15:0]   dropped;
`endif

  modport master (
    output a, factor,
`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
    input  dropped,
`endif
    input  b, pending, busy, overflow
  );

  modport slave (
    input  a, factor,
`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
    output dropped,
`endif
    output b, pending, busy, overflow
  );
endinterface

// File: rtl/multiply_tokens.sv
// multiply_tokens -- serial token multiplier.
// Every input token (a=1) owes fe output '1's in total, where fe is the
// clamped factor. The current cycle's '1' is echoed combinationally; the
// remaining fe-1 are added to a pending counter that drains one per idle
// cycle. Outputs of overlapping tokens are shared, so b = a | (pending != 0).
// A token that would push pending past MAX_PENDING sets a sticky overflow
// flag and freezes pending until rst.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   tok : multiply_tokens_if.slave (a, factor in; b, pending, busy, overflow out)
// Build option: MULTIPLY_TOKENS_DROP_CNT_EN adds tok.dropped, a saturating
// 16-bit count of tokens arriving while overflowed or causing the overflow.
module multiply_tokens #(
  parameter int unsigned FACTOR_MAX = 4,
  parameter int unsigned MAX_RUN    = 200
) (
  input  logic           clk,
  input  logic           rst,
  multiply_tokens_if.slave tok
);
  localparam int unsigned MAX_PENDING = MAX_RUN * (FACTOR_MAX - 1);
  localparam int unsigned PW          = $clog2(MAX_PENDING + 1);

  localparam logic [3:0]    FMAX4     = 4'(FACTOR_MAX);
  localparam logic [PW+3:0] MAX_P_EXT = (PW+4)'(MAX_PENDING);

  logic [PW-1:0] pending_q;
  logic          ovf_q;
  logic [3:0]    fe;
  logic [3:0]    fe_m1;
  logic [PW+3:0] sum;
  logic          ovf_cond;

  always_comb begin
    fe = tok.factor;
    if (tok.factor <= 4'd1) begin
      fe = 4'd1;
    end else if (tok.factor > FMAX4) begin
      fe = FMAX4;
    end
  end

  // Sum carried 4 bits wider than pending so the limit test never wraps.
  assign fe_m1    = fe - 4'd1;
  assign sum      = {4'b0000, pending_q} + {{PW{1'b0}}, fe_m1};
  assign ovf_cond = tok.a && (sum > MAX_P_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else if (!ovf_q) begin
      if (tok.a) begin
        if (ovf_cond) begin
          ovf_q <= 1'b1;
        end else begin
          pending_q <= sum[PW-1:0];
        end
      end else if (pending_q != '0) begin
        pending_q <= pending_q - PW'(1);
      end
    end
  end

  assign tok.b        = tok.a | (pending_q != '0);
  assign tok.busy     = (pending_q != '0);
  assign tok.pending  = pending_q;
  assign tok.overflow = ovf_q;

`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (tok.a && (ovf_q || ovf_cond) && (drop_q != '1)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign tok.dropped = drop_q;
`endif
endmodule

// File: tb/tb_multiply_tokens.sv
// tb_multiply_tokens -- self-checking bench for multiply_tokens
// (FACTOR_MAX=4, MAX_RUN=200). Inputs change on the falling edge and are
// checked 1 time unit later; a token-accounting model tracks owed '1's.
module tb_multiply_tokens;
  localparam int unsigned FM          = 4;
  localparam int unsigned MR          = 200;
  localparam int          MAX_PENDING = 600;
  localparam int unsigned PW          = $clog2(MR * (FM - 1) + 1);

  logic clk;
  logic rst;

  multiply_tokens_if #(.PW(PW)) tok ();

  multiply_tokens #(
    .FACTOR_MAX (FM),
    .MAX_RUN    (MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tok (tok.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference: integer count of owed '1's plus sticky flag.
  int m_owed   = 0;
  bit m_ovf    = 1'b0;
  int m_drop   = 0;
  int fe_sum   = 0;
  int ones     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int f);
    if (f <= 1) return 1;
    if (f > FM) return FM;
    return f;
  endfunction

  task automatic drive(input bit a, input int f, input bit r);
    tok.a      = a;
    tok.factor = 4'(f);
    rst        = r;
    #1;
  endtask

  // Compare outputs with the model, advance model, wait for next falling edge.
  task automatic step();
    int fe;
    bit hit;
    check("b", 32'(tok.b), 32'(tok.a | (m_owed != 0)));
    check("pending", 32'(tok.pending), 32'(m_owed));
    check("busy", 32'(tok.busy), 32'(m_owed != 0));
    check("overflow", 32'(tok.overflow), 32'(m_ovf));
`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
    check("dropped", 32'(tok.dropped), 32'(m_drop));
`endif
    if (tok.b === 1'b1) ones++;
    if (rst) begin
      m_owed = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      fe  = eff(int'(tok.factor));
      hit = tok.a && !m_ovf && (m_owed + fe - 1 > MAX_PENDING);
      if (tok.a && (m_ovf || hit) && m_drop < 65535) m_drop++;
      if (!m_ovf) begin
        if (tok.a) begin
          if (hit) m_ovf = 1'b1;
          else begin
            m_owed += fe - 1;
            fe_sum += fe;
          end
        end else if (m_owed > 0) begin
          m_owed--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit a, input int f, input bit r);
    drive(a, f, r);
    step();
  endtask

  typedef struct {
    bit   a;
    int   f;
    bit   r;
    bit   exp_b;
    int   exp_pend;
    bit   exp_ovf;
  } vec_t;

  vec_t vt[$];

  logic [25:0] pat_a;
  logic [25:0] pat_b;

  initial begin
    // factor 3 single token: b=111 then 0, pending 2,1,0
    vt.push_back('{1'b1, 3, 1'b0, 1'b1, 0, 1'b0});
    vt.push_back('{1'b0, 3, 1'b0, 1'b1, 2, 1'b0});
    vt.push_back('{1'b0, 3, 1'b0, 1'b1, 1, 1'b0});
    vt.push_back('{1'b0, 3, 1'b0, 1'b0, 0, 1'b0});
    // factor 9 clamps to 4
    vt.push_back('{1'b1, 9, 1'b0, 1'b1, 0, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b1, 3, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b1, 2, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b1, 1, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b0, 0, 1'b0});
    // factor 0 and 1: single-cycle echo
    vt.push_back('{1'b1, 0, 1'b0, 1'b1, 0, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b0, 0, 1'b0});
    vt.push_back('{1'b1, 1, 1'b0, 1'b1, 0, 1'b0});
    vt.push_back('{1'b0, 1, 1'b0, 1'b0, 0, 1'b0});
    // reset discards a token
    vt.push_back('{1'b1, 4, 1'b1, 1'b1, 0, 1'b0});
    vt.push_back('{1'b0, 4, 1'b0, 1'b0, 0, 1'b0});

    pat_a = 26'b10010011000110100001100100;
    pat_b = 26'b11011011110111111001111110;

    tok.a = 1'b0;
    tok.factor = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 0, 1'b0);
    m_owed = 0; m_ovf = 1'b0; m_drop = 0;

    // Reset state
    check("reset_pending", 32'(tok.pending), 32'd0);
    check("reset_busy", 32'(tok.busy), 32'd0);
    check("reset_overflow", 32'(tok.overflow), 32'd0);
    step();

    // Table vectors
    foreach (vt[i]) begin
      drive(vt[i].a, vt[i].f, vt[i].r);
      check($sformatf("vec%0d_b", i), 32'(tok.b), 32'(vt[i].exp_b));
      check($sformatf("vec%0d_pending", i), 32'(tok.pending), 32'(vt[i].exp_pend));
      check($sformatf("vec%0d_ovf", i), 32'(tok.overflow), 32'(vt[i].exp_ovf));
      step();
    end

    // Doubler-compatible pattern at factor 2
    for (int i = 25; i >= 0; i--) begin
      drive(pat_a[i], 2, 1'b0);
      check($sformatf("dbl_b%0d", 25 - i), 32'(tok.b), 32'(pat_b[i]));
      step();
    end
    check("dbl_overflow", 32'(tok.overflow), 32'd0);

    // 200 tokens at factor 4 fill pending exactly to the limit
    for (int i = 0; i < 200; i++) cyc(1'b1, 4, 1'b0);
    drive(1'b1, 1, 1'b0);
    check("full_pending", 32'(tok.pending), 32'd600);
    check("full_overflow", 32'(tok.overflow), 32'd0);
    step();
    // fe=1 at the limit is harmless
    drive(1'b1, 4, 1'b0);
    check("fe1_pending", 32'(tok.pending), 32'd600);
    check("fe1_overflow", 32'(tok.overflow), 32'd0);
    step();
    // The factor-4 token above overflowed
    drive(1'b0, 0, 1'b0);
    check("ovf_pending", 32'(tok.pending), 32'd600);
    check("ovf_flag", 32'(tok.overflow), 32'd1);
    step();
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom_range(0, 15), 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, $urandom_range(0, 15), 1'b0);
      check("stuck_b", 32'(tok.b), 32'd1);
      step();
    end
`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
    drive(1'b0, 0, 1'b0);
    check("dropped_six", 32'(tok.dropped), 32'd6);
    step();
`endif

    // Recovery via a single reset cycle
    cyc(1'b1, 4, 1'b1);
    drive(1'b1, 2, 1'b0);
    check("rec_pending", 32'(tok.pending), 32'd0);
    check("rec_overflow", 32'(tok.overflow), 32'd0);
    check("rec_busy", 32'(tok.busy), 32'd0);
    check("rec_b0", 32'(tok.b), 32'd1);
`ifdef MULTIPLY_TOKENS_DROP_CNT_EN
    check("rec_dropped", 32'(tok.dropped), 32'd0);
`endif
    step();
    drive(1'b0, 0, 1'b0);
    check("rec_b1", 32'(tok.b), 32'd1);
    step();
    drive(1'b0, 0, 1'b0);
    check("rec_b2", 32'(tok.b), 32'd0);
    step();

    // Randomized traffic; every token's fe ones must eventually appear
    fe_sum = 0;
    ones   = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) == 0, $urandom_range(0, 15), 1'b0);
    end
    for (int i = 0; i < 700 && m_owed > 0; i++) cyc(1'b0, 0, 1'b0);
    if (!m_ovf) begin
      check("token_total", 32'(ones), 32'(fe_sum));
    end
    drive(1'b0, 0, 1'b0);
    check("drained_busy", 32'(tok.busy), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/multiply_tokens.md
MULTIPLY_TOKENS -- requirements
Module: multiply_tokens

Interface
REQ-001 SHALL have parameter FACTOR_MAX, default 4: largest supported multiplication factor, legal range 2..15.
REQ-002 SHALL have parameter MAX_RUN, default 200: number of back-to-back tokens at FACTOR_MAX that SHALL be absorbed without overflow.
REQ-003 SHALL define localparam MAX_PENDING = MAX_RUN*(FACTOR_MAX-1), and PW = $clog2(MAX_PENDING+1) as the pending-counter width.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 a  input  1  serial token stream; a '1' is one token.
REQ-007 factor  input  4  per-token multiplication factor, sampled only in cycles where a=1.
REQ-008 b  output  1  serial output stream, combinational from a and state.
REQ-009 pending  output  PW  registered count of owed output '1's not yet emitted.
REQ-010 busy  output  1  pending != 0.
REQ-011 overflow  output  1  registered sticky overflow flag.

Function
REQ-012 Effective factor fe: factor 0 or 1 -> 1; factor > FACTOR_MAX -> FACTOR_MAX; otherwise factor.
REQ-013 b SHALL equal a | (pending != 0) in every cycle, including overflow.
REQ-014 No overflow, a=1: pending_next = pending + (fe-1), fe evaluated that cycle.
REQ-015 No overflow, a=0, pending>0: pending_next = pending - 1; a=0, pending=0: hold 0.
REQ-016 Each input token SHALL produce exactly fe output '1's in total; output '1's emitted for overlapping tokens are shared, never lost, so total output '1's = sum of fe over accepted tokens.
REQ-017 With factor held at 2, behaviour SHALL be bit-identical to the predecessor doubler: a=10010011000110100001100100 -> b=11011011110111111001111110.
REQ-018 Overflow condition: a=1 and pending + (fe-1) > MAX_PENDING, evaluated with PW+4 bit arithmetic (no wrap).
REQ-019 On overflow condition: pending SHALL hold its current value, overflow SHALL be 1 from the next cycle.
REQ-020 overflow SHALL be sticky; only rst clears it.
REQ-021 While overflow=1: pending frozen regardless of a and factor; b therefore stuck at 1 if pending>0 at the overflowing cycle.
REQ-022 pending == MAX_PENDING exactly is legal and SHALL NOT raise overflow.
REQ-023 fe=1 tokens SHALL never cause overflow and SHALL leave pending unchanged.

Reset
REQ-024 rst=1 at a clock edge SHALL set pending=0, overflow=0 on that edge; busy=0 and b=a from the following cycle.
REQ-025 rst SHALL take priority over a, factor and overflow state, including mid-burst and while overflowed; a during rst cycles is discarded.

Configuration
REQ-026 Macro MULTIPLY_TOKENS_DROP_CNT_EN SHALL control a dropped-token statistics counter.
REQ-027 Defined: output dropped [15:0] SHALL count every cycle with a=1 while overflow=1 or overflow condition true, saturating at 16'hFFFF, cleared by rst.
REQ-028 Not defined: port dropped and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 factor=2, a=10010011000110100001100100 -> b=11011011110111111001111110, overflow stays 0.
REQ-030 factor=3, single a=1 then zeros -> b=111 then 0; pending 2,1,0; busy deasserts on cycle 3 after token.
REQ-031 factor=4 (FACTOR_MAX=4, MAX_RUN=200), 200 consecutive a=1 -> pending=600, overflow=0; 201st a=1 -> pending holds 600, overflow=1 next cycle, b stays 1 forever after.
REQ-032 factor=9 with FACTOR_MAX=4 -> behaves as 4; factor=0 -> single-cycle echo, pending unchanged.
REQ-033 Overflowed, then rst for 1 cycle -> pending=0, overflow=0, busy=0; a=1, factor=2 next -> b=11.
REQ-034 MULTIPLY_TOKENS_DROP_CNT_EN defined: overflow then 5 cycles a=1 -> dropped=6 (overflowing token plus 5); rst -> 0.
